cmd_seq_fsm: RTL and testbench
==============================

// Module: cmd_seq_fsm
// PURPOSE
//  Parametrised multi-phase command sequencer: on a start request it runs a clock counter and steps through
//  N_STAGES phases, issuing a programmable command code per phase and advancing when the count passes a
//  per-phase threshold. Adds pause, abort, loop mode and config checking. Drives command/stage flags to the datapath.
// PARAMETERS
//  CNT_W     16     counter width (bits)
//  CMD_W     8      command code width (bits)
//  N_STAGES  4      number of phases/thresholds (>=2)
//  IDLE_CMD  8'h00  cmd_type value when not running (CMD_W bits)
//  PH_W      $clog2(N_STAGES)  phase index width (derived, localparam)
// PORTS
//  clk        in   1               system clock, rising edge
//  nReset     in   1               asynchronous reset, active-low
//  start      in   1               run request; sampled in IDLE only
//  pause      in   1               freeze counter/phase while high
//  abort      in   1               terminate run, return to IDLE
//  loop_mode  in   1               1 = restart automatically after DONE
//  thresh     in   N_STAGES*CNT_W  phase k threshold at [k*CNT_W +: CNT_W]
//  cmd_code   in   N_STAGES*CMD_W  phase k command at [k*CMD_W +: CMD_W]
//  cmd_type   out  CMD_W           current command
//  cmd_valid  out  1               high in RUN
//  stage      out  N_STAGES        stage[k] = (clk_cnt > thresh_l[k]); thermometer
//  phase      out  PH_W            current phase index
//  clk_cnt    out  CNT_W           run counter
//  busy       out  1               high in RUN and DONE
//  done       out  1               one-cycle pulse in DONE
//  cfg_err    out  1               one-cycle pulse: start rejected
// BEHAVIOUR
//  Reset (async, nReset=0): state IDLE; clk_cnt=0, phase=0, cmd_type=IDLE_CMD, cmd_valid=0, busy=0,
//   done=0, cfg_err=0; thresh_l/code_l cleared to 0. stage output derives from registers (all 0).
//  States: IDLE, RUN, DONE. All outputs registered except stage (compare of registered clk_cnt vs thresh_l).
//  IDLE: start=1 & abort=0 -> latch thresh/cmd_code into thresh_l/code_l; if config valid -> RUN next edge with
//   clk_cnt=0, phase=0, cmd_type=code[0], cmd_valid=1, busy=1 (latency 1 cycle). Invalid -> cfg_err=1 for 1
//   cycle, stay IDLE. Valid = thresholds strictly increasing AND thresh[N_STAGES-1] < 2^CNT_W-1.
//  RUN, pause=0: clk_cnt += 1 per cycle. If stage[phase]=1 and phase<N_STAGES-1 -> phase+1,
//   cmd_type=code_l[phase+1] next edge (max one advance per cycle). If stage[N_STAGES-1]=1 in last phase -> DONE.
//  RUN, pause=1: clk_cnt, phase, cmd_type held; no advance evaluated.
//  DONE (1 cycle): done=1, cmd_valid=0, cmd_type=IDLE_CMD. Next: loop_mode=1 -> RUN with clk_cnt=0, phase=0,
//   cmd_type=code_l[0] (latched config reused, no re-check); else IDLE. start in DONE ignored.
//  abort: highest priority in RUN/DONE (over pause, advance, loop) -> IDLE next edge, clk_cnt=0, phase=0,
//   cmd_type=IDLE_CMD, no done pulse. abort with start in IDLE -> stay IDLE, no cfg_err.
//  start while busy ignored. thresh/cmd_code changes after start have no effect until next start.
//  clk_cnt holds final value in IDLE after normal completion; counter never wraps (validity guarantees exit).
//  Arithmetic: unsigned compares, CNT_W wide; increment modulo-free.
// STRUCTURE
//  cmd_seq_pkg: state encoding (S_IDLE/S_RUN/S_DONE), default IDLE_CMD, default thresholds/codes for benches.
//  Sub-module cmd_seq_cnt: CNT_W counter with sync clear, enable, async nReset; FSM/compare in top.
// TESTING (defaults; thresh={4095,255,15,7} k=3..0, cmd_code={FF,40,20,80})
//  1 start pulse at T0 -> cmd_type=80 T1; stage[0] when clk_cnt=8, cmd 20 next edge; 40 after cnt=16; FF
//    after cnt=256; done pulse 1 cycle after cnt=4096 seen, then IDLE, cmd_type=00, clk_cnt holds 4096.
//  2 pause high 10 cycles at clk_cnt=100 -> clk_cnt/phase/cmd_type frozen at 100/2/40, resume counts 101.
//  3 abort at clk_cnt=300 (with pause=1) -> next edge IDLE, clk_cnt=0, cmd_type=00, done never pulses.
//  4 loop_mode=1 -> after done pulse, RUN restarts, cmd_type=80, clk_cnt=0; two full runs without start.
//  5 thresh={4095,255,15,15} or thresh[3]=FFFF, start -> cfg_err 1 cycle, busy stays 0.
//  6 nReset low at clk_cnt=20 mid-run -> all outputs at reset values immediately (async); start after works.

Source files
------------

// File: rtl/cmd_seq_pkg.sv
// Shared state encoding and default configuration for the command sequencer.
package cmd_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0]  DEF_IDLE_CMD = 8'h00;
  localparam logic [63:0] DEF_THRESH   = {16'd4095, 16'd255, 16'd15, 16'd7};
  localparam logic [31:0] DEF_CMD_CODE = {8'hFF, 8'h40, 8'h20, 8'h80};

endpackage

// File: rtl/cmd_seq_cnt.sv
// Run counter: synchronous clear has priority over enable; no wrap handling needed.
module cmd_seq_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cmd_seq_fsm.sv
// Multi-phase command sequencer: steps phases on threshold crossings, one-cycle start latency.
// pause freezes counter/phase/command; abort returns to IDLE with top priority.
module cmd_seq_fsm
  import cmd_seq_pkg::*;
#(
  parameter int                CNT_W    = 16,
  parameter int                CMD_W    = 8,
  parameter int                N_STAGES = 4,
  parameter logic [CMD_W-1:0]  IDLE_CMD = CMD_W'(DEF_IDLE_CMD),
  localparam int               PH_W     = $clog2(N_STAGES)
) (
  input  logic                      clk,
  input  logic                      nReset,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      abort,
  input  logic                      loop_mode,
  input  logic [N_STAGES*CNT_W-1:0] thresh,
  input  logic [N_STAGES*CMD_W-1:0] cmd_code,
  output logic [CMD_W-1:0]          cmd_type,
  output logic                      cmd_valid,
  output logic [N_STAGES-1:0]       stage,
  output logic [PH_W-1:0]           phase,
  output logic [CNT_W-1:0]          clk_cnt,
  output logic                      busy,
  output logic                      done,
  output logic                      cfg_err
);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(N_STAGES - 1);

  state_e                    state_q, state_d;
  logic [PH_W-1:0]           phase_q, phase_d;
  logic [CMD_W-1:0]          cmd_q, cmd_d;
  logic                      vld_q, vld_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [N_STAGES*CNT_W-1:0] thresh_q, thresh_d;
  logic [N_STAGES*CMD_W-1:0] code_q, code_d;
  logic                      cnt_clr, cnt_en;
  logic                      cfg_ok;
  logic [PH_W-1:0]           phase_inc;

  cmd_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .nReset (nReset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (clk_cnt)
  );

  // Last threshold must stay below all-ones so the counter always crosses it before wrapping.
  always_comb begin
    cfg_ok = (thresh[(N_STAGES-1)*CNT_W +: CNT_W] != {CNT_W{1'b1}});
    for (int k = 1; k < N_STAGES; k++) begin
      if (thresh[k*CNT_W +: CNT_W] <= thresh[(k-1)*CNT_W +: CNT_W]) begin
        cfg_ok = 1'b0;
      end
    end
  end

  always_comb begin
    stage = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      stage[k] = (clk_cnt > thresh_q[k*CNT_W +: CNT_W]);
    end
  end

  assign phase_inc = phase_q + PH_W'(1);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    cmd_d    = cmd_q;
    vld_d    = vld_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    thresh_d = thresh_q;
    code_d   = code_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          thresh_d = thresh;
          code_d   = cmd_code;
          if (cfg_ok) begin
            state_d = S_RUN;
            cnt_clr = 1'b1;
            phase_d = '0;
            cmd_d   = cmd_code[CMD_W-1:0];
            vld_d   = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_clr = 1'b1;
          phase_d = '0;
          cmd_d   = IDLE_CMD;
          vld_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (!pause) begin
          // Finishing freezes the counter so IDLE shows the crossing value.
          if (phase_q == LAST_PH && stage[N_STAGES-1]) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            vld_d   = 1'b0;
            cmd_d   = IDLE_CMD;
          end else begin
            cnt_en = 1'b1;
            if (phase_q != LAST_PH && stage[phase_q]) begin
              phase_d = phase_inc;
              cmd_d   = code_q[int'(phase_inc)*CMD_W +: CMD_W];
            end
          end
        end
      end

      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_clr = 1'b1;
          phase_d = '0;
          cmd_d   = IDLE_CMD;
          busy_d  = 1'b0;
        end else if (loop_mode) begin
          state_d = S_RUN;
          cnt_clr = 1'b1;
          phase_d = '0;
          cmd_d   = code_q[CMD_W-1:0];
          vld_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      cmd_q    <= IDLE_CMD;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      thresh_q <= '0;
      code_q   <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      cmd_q    <= cmd_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      thresh_q <= thresh_d;
      code_q   <= code_d;
    end
  end

  assign cmd_type  = cmd_q;
  assign cmd_valid = vld_q;
  assign phase     = phase_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_cmd_seq_fsm.sv
// Directed bench for cmd_seq_fsm with a queue of expected command-change events.
module tb_cmd_seq_fsm;

  logic        clk;
  logic        nReset;
  logic        start, pause, abort, loop_mode;
  logic [63:0] thresh;
  logic [31:0] cmd_code;
  logic [7:0]  cmd_type;
  logic        cmd_valid;
  logic [3:0]  stage;
  logic [1:0]  phase;
  logic [15:0] clk_cnt;
  logic        busy, done, cfg_err;

  localparam logic [63:0] THR_DEF  = {16'd4095, 16'd255, 16'd15, 16'd7};
  localparam logic [31:0] CODE_DEF = {8'hFF, 8'h40, 8'h20, 8'h80};

  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] cnt;
    logic        dn;
  } ev_t;

  ev_t        sb[$];
  logic [7:0] prev_cmd;
  int         n_assert = 0;
  int         n_fail   = 0;

  cmd_seq_fsm dut (
    .clk       (clk),
    .nReset    (nReset),
    .start     (start),
    .pause     (pause),
    .abort     (abort),
    .loop_mode (loop_mode),
    .thresh    (thresh),
    .cmd_code  (cmd_code),
    .cmd_type  (cmd_type),
    .cmd_valid (cmd_valid),
    .stage     (stage),
    .phase     (phase),
    .clk_cnt   (clk_cnt),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One normal run with default thresholds/codes, as seen from outside.
  task automatic push_run();
    sb.push_back('{cmd: 8'h80, cnt: 16'd0,    dn: 1'b0});
    sb.push_back('{cmd: 8'h20, cnt: 16'd9,    dn: 1'b0});
    sb.push_back('{cmd: 8'h40, cnt: 16'd17,   dn: 1'b0});
    sb.push_back('{cmd: 8'hFF, cnt: 16'd257,  dn: 1'b0});
    sb.push_back('{cmd: 8'h00, cnt: 16'd4096, dn: 1'b1});
  endtask

  task automatic watch(input int budget);
    ev_t e;
    int  n = 0;
    while (sb.size() > 0 && n < budget) begin
      if (cmd_type !== prev_cmd || done === 1'b1) begin
        e = sb.pop_front();
        chk("ev_cmd",  32'(cmd_type), 32'(e.cmd));
        chk("ev_cnt",  32'(clk_cnt),  32'(e.cnt));
        chk("ev_done", 32'(done),     32'(e.dn));
      end
      prev_cmd = cmd_type;
      step();
      n++;
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int budget);
    int n = 0;
    while (clk_cnt !== target && n < budget) begin
      step();
      n++;
    end
    chk("reach_cnt", 32'(clk_cnt), 32'(target));
  endtask

  initial begin
    logic done_seen;
    start = 0; pause = 0; abort = 0; loop_mode = 0;
    thresh = THR_DEF; cmd_code = CODE_DEF;
    nReset = 1'b1;
    #2 nReset = 1'b0;
    #1;
    chk("rst_cmd",   32'(cmd_type),  32'h00);
    chk("rst_vld",   32'(cmd_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_err",   32'(cfg_err),   32'd0);
    chk("rst_cnt",   32'(clk_cnt),   32'd0);
    chk("rst_stage", 32'(stage),     32'd0);
    step();
    nReset = 1'b1;
    step();

    // Normal run
    push_run();
    prev_cmd = 8'h00;
    start = 1; step(); start = 0;
    chk("t1_vld",  32'(cmd_valid), 32'd1);
    chk("t1_busy", 32'(busy),      32'd1);
    watch(5000);
    chk("t1_idle_busy", 32'(busy),      32'd0);
    chk("t1_idle_vld",  32'(cmd_valid), 32'd0);
    chk("t1_idle_cmd",  32'(cmd_type),  32'h00);
    chk("t1_idle_cnt",  32'(clk_cnt),   32'd4096);

    // Pause, plus config changes and start while busy are ignored
    start = 1; step(); start = 0;
    thresh = {16'hFFFF, 16'd1, 16'd1, 16'd1};
    cmd_code = 32'h55555555;
    wait_cnt(16'd50, 200);
    start = 1; step(); start = 0;
    chk("t2_start_busy", 32'(clk_cnt), 32'd51);
    wait_cnt(16'd100, 200);
    pause = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_hold_cnt", 32'(clk_cnt), 32'd100);
    end
    chk("t2_phase", 32'(phase),    32'd2);
    chk("t2_cmd",   32'(cmd_type), 32'h40);
    chk("t2_stage", 32'(stage),    32'b0011);
    pause = 0; step();
    chk("t2_resume", 32'(clk_cnt), 32'd101);

    // Abort beats pause
    wait_cnt(16'd300, 400);
    pause = 1; abort = 1; step();
    chk("t3_busy",  32'(busy),      32'd0);
    chk("t3_vld",   32'(cmd_valid), 32'd0);
    chk("t3_cnt",   32'(clk_cnt),   32'd0);
    chk("t3_cmd",   32'(cmd_type),  32'h00);
    chk("t3_phase", 32'(phase),     32'd0);
    done_seen = done;
    pause = 0; abort = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      done_seen = done_seen | done;
    end
    chk("t3_no_done", 32'(done_seen), 32'd0);

    // Loop mode: two runs from a single start
    thresh = THR_DEF; cmd_code = CODE_DEF; loop_mode = 1;
    push_run();
    push_run();
    prev_cmd = 8'h00;
    start = 1; step(); start = 0;
    watch(10000);
    chk("t4_restart_cmd",  32'(cmd_type), 32'h80);
    chk("t4_restart_cnt",  32'(clk_cnt),  32'd0);
    chk("t4_restart_busy", 32'(busy),     32'd1);
    loop_mode = 0; abort = 1; step(); abort = 0;
    chk("t4_abort_busy", 32'(busy), 32'd0);

    // Config errors
    thresh = {16'd4095, 16'd255, 16'd15, 16'd15};
    start = 1; step(); start = 0;
    chk("t5_eq_err",  32'(cfg_err), 32'd1);
    chk("t5_eq_busy", 32'(busy),    32'd0);
    step();
    chk("t5_err_pulse", 32'(cfg_err), 32'd0);
    thresh = {16'hFFFF, 16'd255, 16'd15, 16'd7};
    start = 1; step(); start = 0;
    chk("t5_max_err",  32'(cfg_err), 32'd1);
    chk("t5_max_busy", 32'(busy),    32'd0);
    start = 1; abort = 1; step(); start = 0; abort = 0;
    chk("t5_abort_err",  32'(cfg_err), 32'd0);
    chk("t5_abort_busy", 32'(busy),    32'd0);

    // Asynchronous reset mid-run
    thresh = THR_DEF;
    start = 1; step(); start = 0;
    wait_cnt(16'd20, 100);
    #2 nReset = 1'b0;
    #1;
    chk("t6_cnt",   32'(clk_cnt),   32'd0);
    chk("t6_cmd",   32'(cmd_type),  32'h00);
    chk("t6_vld",   32'(cmd_valid), 32'd0);
    chk("t6_busy",  32'(busy),      32'd0);
    chk("t6_phase", 32'(phase),     32'd0);
    chk("t6_stage", 32'(stage),     32'd0);
    step();
    nReset = 1'b1;
    step();
    start = 1; step(); start = 0;
    chk("t6_rs_cmd",  32'(cmd_type), 32'h80);
    chk("t6_rs_busy", 32'(busy),     32'd1);
    wait_cnt(16'd9, 50);
    chk("t6_rs_cmd2",  32'(cmd_type), 32'h20);
    chk("t6_rs_phase", 32'(phase),    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
